// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage request at a time into word
// transactions on a single-port, word-only data memory. Sub-word stores use
// read-modify-write; sub-word loads are aligned and extended here.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// READ  | word read issued to memory
// MERGE | read data valid: finish load, or write merged word for SB/SH
// WRITE | full-word store written directly (SW)
// FAULT | illegal/misaligned request reported, memory untouched
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_load,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_WriteData,
    output logic            mem_WriteEnable,
    output logic            mem_MemRead,
    input  logic [XLEN-1:0] mem_ReadData
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      funct3_q;
    logic            is_load_q;

    logic            accept;
    logic            req_fault;
    logic            legal_kind;
    logic            legal_f3;
    logic            aligned;
    logic [XLEN-1:0] word_addr;
    logic [4:0]      lane_shift;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;

    assign accept = req_valid && req_ready;

    // Legality of the incoming request, evaluated at acceptance only
    always_comb begin
        legal_kind = req_is_load ^ req_is_store;
        legal_f3   = 1'b0;
        if (req_is_load) begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end else if (req_is_store) begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end
        case (req_funct3[1:0])
            2'b01:   aligned = (req_addr[0] == 1'b0);
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        req_fault = !legal_kind || !legal_f3 || !aligned;
    end

    // State register and request latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= 3'b000;
            is_load_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                funct3_q  <= req_funct3;
                is_load_q <= req_is_load;
            end
        end
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        word_addr  = {addr_q[XLEN-1:2], 2'b00};
        lane_shift = {addr_q[1:0], 3'b000};
        shifted    = mem_ReadData >> lane_shift;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = mem_ReadData;
        endcase
        if (funct3_q[1:0] == 2'b00) begin
            merged = (mem_ReadData & ~({{(XLEN-8){1'b0}}, 8'hFF} << lane_shift)) |
                     ({{(XLEN-8){1'b0}}, wdata_q[7:0]} << lane_shift);
        end else begin
            merged = (mem_ReadData & ~({{(XLEN-16){1'b0}}, 16'hFFFF} << lane_shift)) |
                     ({{(XLEN-16){1'b0}}, wdata_q[15:0]} << lane_shift);
        end
    end

    // Next-state and outputs; everything held quiet while reset is high
    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_fault      = 1'b0;
        resp_rdata      = '0;
        mem_address     = '0;
        mem_WriteData   = '0;
        mem_WriteEnable = 1'b0;
        mem_MemRead     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (req_fault)
                            state_next = FAULT;
                        else if (req_is_store && (req_funct3 == 3'b010))
                            state_next = WRITE;
                        else
                            state_next = READ;
                    end
                end
                READ: begin
                    mem_MemRead = 1'b1;
                    mem_address = word_addr;
                    state_next  = MERGE;
                end
                MERGE: begin
                    resp_valid = 1'b1;
                    state_next = IDLE;
                    if (is_load_q) begin
                        resp_rdata = load_data;
                    end else begin
                        mem_WriteEnable = 1'b1;
                        mem_address     = word_addr;
                        mem_WriteData   = merged;
                    end
                end
                WRITE: begin
                    mem_WriteEnable = 1'b1;
                    mem_address     = word_addr;
                    mem_WriteData   = wdata_q;
                    resp_valid      = 1'b1;
                    state_next      = IDLE;
                end
                FAULT: begin
                    resp_valid = 1'b1;
                    resp_fault = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small registered-read memory
// model that clears on reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_WriteData;
    logic        mem_WriteEnable;
    logic        mem_MemRead;
    logic [31:0] mem_ReadData;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_WriteData(mem_WriteData),
        .mem_WriteEnable(mem_WriteEnable), .mem_MemRead(mem_MemRead),
        .mem_ReadData(mem_ReadData)
    );

    // Word memory: registered read data, cleared by reset
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem_ReadData <= 32'h0;
        end else begin
            if (mem_WriteEnable) mem[mem_address[7:2]] <= mem_WriteData;
            if (mem_MemRead) mem_ReadData <= mem[mem_address[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge and follow it to its response
    task automatic txn(input string tag, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_fault,
                       input int exp_we_cyc, input logic [31:0] exp_wdata,
                       input logic exp_rd_seen);
        int          lat;
        int          we_cyc;
        logic        rd_seen;
        logic        both;
        logic        ready_busy;
        logic [31:0] we_data;
        lat = 0; we_cyc = 0; rd_seen = 1'b0; both = 1'b0; ready_busy = 1'b0; we_data = 32'h0;
        req_is_load = ld; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1 chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5; req_funct3 = 3'b111;
        req_is_load = 1'b0; req_is_store = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            if (mem_MemRead) rd_seen = 1'b1;
            if (mem_MemRead && mem_WriteEnable) both = 1'b1;
            if (req_ready) ready_busy = 1'b1;
            if (mem_WriteEnable && we_cyc == 0) begin
                we_cyc = k;
                we_data = mem_WriteData;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".fault"}, {31'b0, resp_fault}, {31'b0, exp_fault});
        chk({tag, ".we_cycle"}, we_cyc, exp_we_cyc);
        if (exp_we_cyc != 0) chk({tag, ".wdata"}, we_data, exp_wdata);
        chk({tag, ".read_seen"}, {31'b0, rd_seen}, {31'b0, exp_rd_seen});
        chk({tag, ".rd_and_we"}, {31'b0, both}, 32'd0);
        chk({tag, ".busy_ready"}, {31'b0, ready_busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int accepts;
        int last;
        int resps;
        logic spacing_ok;

        reset = 1'b1; req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.ready", {31'b0, req_ready}, 32'd0);
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst.fault", {31'b0, resp_fault}, 32'd0);
        chk("rst.we", {31'b0, mem_WriteEnable}, 32'd0);
        chk("rst.memread", {31'b0, mem_MemRead}, 32'd0);
        chk("rst.addr", mem_address, 32'd0);
        chk("rst.wdata", mem_WriteData, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        //   tag       ld    st    f3      addr   wdata          lat rdata          flt we wdata         rd
        txn("sw10",   1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0,        1'b0, 1, 32'hDEADBEEF, 1'b0);
        txn("lw10",   1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0, 0, 32'h0,        1'b1);
        txn("lb13",   1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        2, 32'hFFFFFFDE, 1'b0, 0, 32'h0,        1'b1);
        txn("lbu13",  1'b1, 1'b0, 3'b100, 32'h13, 32'h0,        2, 32'h000000DE, 1'b0, 0, 32'h0,        1'b1);
        txn("lh12",   1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        2, 32'hFFFFDEAD, 1'b0, 0, 32'h0,        1'b1);
        txn("lhu10",  1'b1, 1'b0, 3'b101, 32'h10, 32'h0,        2, 32'h0000BEEF, 1'b0, 0, 32'h0,        1'b1);
        txn("lb11",   1'b1, 1'b0, 3'b000, 32'h11, 32'h0,        2, 32'hFFFFFFBE, 1'b0, 0, 32'h0,        1'b1);
        txn("sb11",   1'b0, 1'b1, 3'b000, 32'h11, 32'h12345655, 2, 32'h0,        1'b0, 2, 32'hDEAD55EF, 1'b1);
        txn("lw_sb",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        2, 32'hDEAD55EF, 1'b0, 0, 32'h0,        1'b1);
        txn("sh12",   1'b0, 1'b1, 3'b001, 32'h12, 32'h00007F00, 2, 32'h0,        1'b0, 2, 32'h7F0055EF, 1'b1);
        txn("lw_sh",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        2, 32'h7F0055EF, 1'b0, 0, 32'h0,        1'b1);
        txn("f_lw12", 1'b1, 1'b0, 3'b010, 32'h12, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0,        1'b0);
        txn("f_sh11", 1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFF,     1, 32'h0,        1'b1, 0, 32'h0,        1'b0);
        txn("f_both", 1'b1, 1'b1, 3'b010, 32'h10, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0,        1'b0);
        txn("f_none", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0,        1'b0);
        txn("f_st100",1'b0, 1'b1, 3'b100, 32'h10, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0,        1'b0);
        txn("f_ld011",1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0,        1'b0);
        txn("lw_keep",1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        2, 32'h7F0055EF, 1'b0, 0, 32'h0,        1'b1);

        // Reset while an SB sits in MERGE: no write, no response
        req_is_load = 1'b0; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h000000AA; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 chk("rmw.in_merge_resp", {31'b0, resp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rmw.rst_we", {31'b0, mem_WriteEnable}, 32'd0);
        chk("rmw.rst_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        #1 chk("rmw.rst_ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b0;
        #1 chk("rmw.ready_after", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        txn("lw_clr", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h0, 1'b0, 0, 32'h0, 1'b1);

        // req_valid held high across four loads: one accept every third cycle
        req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_valid = 1'b1;
        accepts = 0; last = -1; resps = 0; spacing_ok = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (resp_valid) resps++;
            if (req_ready) begin
                if (last >= 0 && (c - last) != 3) spacing_ok = 1'b0;
                last = c;
                accepts++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        #1 if (resp_valid) resps++;
        chk("b2b.accepts", accepts, 4);
        chk("b2b.spacing", {31'b0, spacing_ok}, 32'd1);
        chk("b2b.resps", resps, 4);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
